// File: rtl/param_down_counter.sv
// Edge-triggered wrap counter: counts rising edges of in_pulse down (START..0) or up (0..START),
// with a one-cycle out_pulse on each wrap. Define COUNTER_LOAD_EN to add a synchronous load port.
module param_down_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned START = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             in_pulse,
  input  logic             up,
`ifdef COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic             out_pulse,
  output logic [WIDTH-1:0] cur_value,
  output logic             zero
);

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

  logic             in_q,        in_d;
  logic [WIDTH-1:0] count_q,     count_d;
  logic             out_pulse_q, out_pulse_d;
  logic             tick;

  assign tick = in_pulse & ~in_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    in_d        = in_pulse;
    count_d     = count_q;
    out_pulse_d = 1'b0;

`ifdef COUNTER_LOAD_EN
    if (load) begin
      // Load wins over a coincident tick, which is simply dropped.
      count_d = (load_value > START_V) ? START_V : load_value;
    end else
`endif
    if (enable && tick) begin
      if (up) begin
        if (count_q >= START_V) begin
          count_d     = '0;
          out_pulse_d = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d     = START_V;
          out_pulse_d = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // in_q comes out of reset high so a level already present at release is not a tick.
      in_q        <= 1'b1;
      count_q     <= START_V;
      out_pulse_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
      in_q        <= in_d;
      count_q     <= count_d;
      out_pulse_q <= out_pulse_d;
    end
  end

  assign cur_value = count_q;
  assign out_pulse = out_pulse_q;
  assign zero      = (count_q == '0);

endmodule

// File: tb/tb_param_down_counter.sv
// Randomized + directed bench for param_down_counter; a modular-arithmetic model checks two
// instances (START=5 and START=0) every cycle. Load checks run when COUNTER_LOAD_EN is defined.
module tb_param_down_counter;

  localparam int WIDTH = 4;
  localparam int START_P [2] = '{5, 0};

  logic clk;
  logic resetn;
  logic enable;
  logic in_pulse;
  logic up;
  logic load;
  logic [WIDTH-1:0] load_value;

  logic             out_pulse,   z_out_pulse;
  logic [WIDTH-1:0] cur_value,   z_cur_value;
  logic             zero,        z_zero;

  int total = 0;
  int bad   = 0;

  param_down_counter #(.WIDTH(WIDTH), .START(5)) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .in_pulse   (in_pulse),
    .up         (up),
`ifdef COUNTER_LOAD_EN
    .load       (load),
    .load_value (load_value),
`endif
    .out_pulse  (out_pulse),
    .cur_value  (cur_value),
    .zero       (zero)
  );

  param_down_counter #(.WIDTH(WIDTH), .START(0)) u_zero (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .in_pulse   (in_pulse),
    .up         (up),
`ifdef COUNTER_LOAD_EN
    .load       (load),
    .load_value (load_value),
`endif
    .out_pulse  (z_out_pulse),
    .cur_value  (z_cur_value),
    .zero       (z_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the counter is a residue mod (START+1); a wrap is leaving 0 going down
  // or arriving at 0 going up.
  int m_val   [2];
  bit m_pulse [2];
  bit m_prev_in;
  bit load_active;
  int nxt;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_prev_in <= 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_val[k]   <= START_P[k];
        m_pulse[k] <= 1'b0;
      end
    end else begin
      m_prev_in <= in_pulse;
      for (int k = 0; k < 2; k++) begin
        m_pulse[k] <= 1'b0;
        if (load_active && load) begin
          m_val[k] <= (int'(load_value) > START_P[k]) ? START_P[k] : int'(load_value);
        end else if (enable && in_pulse && !m_prev_in) begin
          if (up) begin
            nxt = (m_val[k] + 1) % (START_P[k] + 1);
            m_val[k]   <= nxt;
            m_pulse[k] <= (nxt == 0);
          end else begin
            m_val[k]   <= (m_val[k] + START_P[k]) % (START_P[k] + 1);
            m_pulse[k] <= (m_val[k] == 0);
          end
        end
      end
    end
  end

  bit compare_on = 1'b0;

  always @(negedge clk) begin
    if (compare_on) begin
      check("cur_value",   cur_value,   m_val[0]);
      check("out_pulse",   out_pulse,   m_pulse[0]);
      check("zero",        zero,        m_val[0] == 0);
      check("z_cur_value", z_cur_value, m_val[1]);
      check("z_out_pulse", z_out_pulse, m_pulse[1]);
      check("z_zero",      z_zero,      m_val[1] == 0);
    end
  end

  // One rising edge on in_pulse; returns at the negedge after the counting posedge.
  task automatic tick_once();
    @(negedge clk) in_pulse = 1'b1;
    @(negedge clk) in_pulse = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b0;
    in_pulse = 1'b0;
    @(negedge clk) resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int down_exp [7] = '{4, 3, 2, 1, 0, 5, 4};
    int up_exp   [6] = '{0, 1, 2, 3, 4, 5};
    int zpulses;

`ifdef COUNTER_LOAD_EN
    load_active = 1'b1;
`else
    load_active = 1'b0;
`endif
    resetn     = 1'b0;
    enable     = 1'b1;
    in_pulse   = 1'b0;
    up         = 1'b0;
    load       = 1'b0;
    load_value = '0;

    repeat (2) @(negedge clk);
    check("reset cur_value", cur_value, 5);
    check("reset out_pulse", out_pulse, 0);
    check("reset zero",      zero,      0);
    check("reset z_zero",    z_zero,    1);
    compare_on = 1'b1;
    resetn     = 1'b1;

    // Down count through a wrap; the START=0 instance pulses on every tick.
    zpulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick_once();
      check("down seq value", cur_value, down_exp[i]);
      check("down seq pulse", out_pulse, (i == 5));
      check("start0 value",   z_cur_value, 0);
      if (i < 4) zpulses += int'(z_out_pulse);
    end
    check("start0 pulses in 4 ticks", zpulses, 4);

    // Held level counts once.
    @(negedge clk) in_pulse = 1'b1;
    repeat (10) @(negedge clk);
    in_pulse = 1'b0;
    @(negedge clk);
    check("held level one decrement", cur_value, 3);

    // Disabled ticks are lost.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_once();
      check("disabled value", cur_value, 3);
      check("disabled pulse", out_pulse, 0);
    end
    enable = 1'b1;
    tick_once();
    check("after enable value", cur_value, 2);

    // Async reset between edges with in_pulse high across release.
    in_pulse = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("async reset value", cur_value, 5);
    check("async reset pulse", out_pulse, 0);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no tick at release", cur_value, 5);
    end
    in_pulse = 1'b0;
    tick_once();
    check("fresh edge after reset", cur_value, 4);

    // Up mode from reset, then a mode change mid-count.
    do_reset();
    up = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick_once();
      check("up seq value", cur_value, up_exp[i]);
      check("up seq pulse", out_pulse, (i == 0));
    end
    up = 1'b0;
    tick_once();
    check("mode change value", cur_value, 4);

`ifdef COUNTER_LOAD_EN
    @(negedge clk);
    load = 1'b1;
    load_value = 4'd12;
    @(negedge clk) load = 1'b0;
    check("load clamp", cur_value, 5);
    load = 1'b1;
    load_value = 4'd3;
    in_pulse = 1'b1;
    @(negedge clk);
    load = 1'b0;
    in_pulse = 1'b0;
    check("load beats tick value", cur_value, 3);
    check("load beats tick pulse", out_pulse, 0);
`endif

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_pulse = 1'($urandom_range(0, 1));
      enable   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      load       = load_active && ($urandom_range(0, 15) == 0);
      load_value = WIDTH'($urandom_range(0, 15));
      resetn     = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    resetn = 1'b1;
    load   = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_down_counter.md
PARAM_DOWN_COUNTER -- requirements
Module: param_down_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the count register and value ports.
REQ-002 Parameter START, default 5: reload/terminal value; legal range 0 to 2**WIDTH-1.
REQ-003 Port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-004 Port resetn, input, 1: reset, asynchronous, active-low.
REQ-005 Port enable, input, 1: 1 = ticks are counted; 0 = ticks are ignored.
REQ-006 Port in_pulse, input, 1: count request, synchronous to clk; each 0->1 transition is one tick.
REQ-007 Port up, input, 1: mode select; 0 = count down (START..0), 1 = count up (0..START).
REQ-008 Port load, input, 1: synchronous load strobe (present only with COUNTER_LOAD_EN).
REQ-009 Port load_value, input, WIDTH: value to load (present only with COUNTER_LOAD_EN).
REQ-010 Port out_pulse, output, 1: one-cycle registered pulse on each wrap.
REQ-011 Port cur_value, output, WIDTH: current registered count.
REQ-012 Port zero, output, 1: combinational, 1 when cur_value == 0.

Function
REQ-013 Tick detect: in_q SHALL register in_pulse every clk; tick = in_pulse & ~in_q; a level held high SHALL produce exactly one tick.
REQ-014 Down mode, tick with enable=1: cur_value != 0 -> cur_value-1; cur_value == 0 -> START (wrap).
REQ-015 Up mode, tick with enable=1: cur_value < START -> cur_value+1; cur_value >= START -> 0 (wrap).
REQ-016 out_pulse SHALL be 1 for exactly the single clk cycle following a wrapping tick, coincident with cur_value showing the wrapped value; otherwise 0.
REQ-017 Latency: cur_value updates on the first posedge at which tick is sampled high (one clk after in_pulse rises).
REQ-018 enable=0: cur_value and out_pulse=0 held; in_q SHALL still track in_pulse, so an edge occurring while disabled is lost, not deferred.
REQ-019 Changing up mid-count SHALL take effect on the next tick without altering cur_value.
REQ-020 START=0: every enabled tick is a wrap; cur_value stays 0; out_pulse fires on every tick.
REQ-021 No intermediate value outside 0..START SHALL be reachable except through load (see REQ-025).

Reset
REQ-022 resetn=0 SHALL immediately, without clk, force cur_value=START, out_pulse=0, in_q=1.
REQ-023 in_q resets to 1 so that in_pulse already high at reset release produces no tick.
REQ-024 Reset asserted mid-count SHALL abandon the count; no out_pulse is generated by reset.

Configuration
REQ-025 Macro COUNTER_LOAD_EN defined: load/load_value ports exist; load=1 at posedge sets cur_value=min(load_value, START), regardless of enable; load has priority over a coincident tick, which is discarded; load produces no out_pulse.
REQ-026 COUNTER_LOAD_EN undefined: load/load_value ports and load logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-027 WIDTH=4, START=5, up=0, enable=1, 7 single-cycle in_pulse ticks -> cur_value 4,3,2,1,0,5,4; out_pulse high exactly once, in the cycle cur_value becomes 5.
REQ-028 up=1, START=5, 6 ticks from reset -> cur_value: reset value 5 wraps to 0 on the first tick (out_pulse), then 1,2,3,4,5.
REQ-029 in_pulse held high for 10 clk -> exactly one decrement; enable=0 across 3 ticks -> cur_value unchanged, out_pulse=0.
REQ-030 resetn pulsed low between clk edges at cur_value=2 -> cur_value=5 immediately; in_pulse=1 at release -> no tick until a fresh 0->1 edge.
REQ-031 COUNTER_LOAD_EN, load_value=12, START=5 -> cur_value=5; load=1 and tick in the same cycle with load_value=3 -> cur_value=3, out_pulse=0.
REQ-032 START=0, 4 ticks -> cur_value stays 0, zero=1, 4 out_pulses.
